xsw_pkt_nm: RTL and testbench
=============================

XSW_PKT_NM -- requirements
Module: xsw_pkt_nm

Interface
REQ-001 SHALL have parameter N, default 2: number of input ports, 1..16.
REQ-002 SHALL have parameter M, default 2: number of output ports, 1..16.
REQ-003 SHALL have parameter DW, default 8: flit data width.
REQ-004 SHALL have parameter ARB, default 0: arbitration mode, 0 = round robin, 1 = fixed priority (lowest index wins).
REQ-005 SHALL define widths IW = max(1,clog2(M)) and SW = max(1,clog2(N)).
REQ-006 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have ports vld_i (input, N), dat_i (input, N*DW), lst_i (input, N, last flit of packet), dst_i (input, N*IW, destination output index) and gnt_i (output, N).
REQ-009 SHALL have ports vld_o (output, M), dat_o (output, M*DW), lst_o (output, M), src_o (output, M*SW, winning input index) and gnt_o (input, M).

Function
REQ-010 A transfer SHALL occur on a port in any cycle where vld and gnt are both high.
REQ-011 gnt_i[i] SHALL be high only when vld_i[i] is high, input i holds arbitration at output dst_i[i], and that output path can accept.
REQ-012 vld_o SHALL NOT depend combinationally on gnt_o.
REQ-013 Each output SHALL run an FSM with states IDLE and LOCK.
REQ-014 In IDLE, an output SHALL select one winner from the inputs with vld_i high and dst_i equal to its index.
REQ-015 On an accepted flit with lst_i=0 in IDLE, the output SHALL go to LOCK and store the winner as owner.
REQ-016 In LOCK, only the owner SHALL be granted, and flits from different packets SHALL never interleave.
REQ-017 On an accepted flit with lst_i=1, the output SHALL return to IDLE; a single-flit packet leaves the output in IDLE.
REQ-018 With ARB=0, the round-robin pointer SHALL move to owner+1 (wrapping N-1 to 0) only on an accepted last flit; search starts at the pointer.
REQ-019 With ARB=1, no pointer SHALL exist and the lowest-index requester SHALL win in IDLE.
REQ-020 An input with dst_i >= M SHALL never be granted.
REQ-021 Different outputs SHALL transfer in parallel in the same cycle.
REQ-022 dst_i and dat_i SHALL be stable while vld_i is high and gnt_i is low, and dst_i SHALL be constant within a packet.
REQ-023 src_o SHALL carry the input index of the flit currently on dat_o.

Reset
REQ-024 While rst is high, vld_o and gnt_i SHALL be 0, all FSMs SHALL be IDLE, all pointers 0, and the output slices empty.
REQ-025 dat_o, lst_o and src_o SHALL reset to 0.
REQ-026 A reset asserted mid-packet SHALL drop the packet, with no further flits of it driven out.

Configuration
REQ-027 With macro XSW_PKT_NM_OUT_SLICE_EN defined, each output SHALL have a one-entry register slice.
REQ-028 In slice mode, latency SHALL be 1 cycle, the slice SHALL accept when empty or when gnt_o is high, and full throughput SHALL be kept.
REQ-029 Without the macro, the output path SHALL be combinational with 0-cycle latency and gnt_i derived from gnt_o.

Structure
REQ-030 A package xsw_pkg SHALL hold the arbitration mode enum, the output FSM state enum, and a safe-clog2 function.
REQ-031 Per-output arbitration and FSM SHALL live in sub-module xsw_pkt_arb, instantiated M times.
REQ-032 Simulation-only assertions SHALL check: gnt_i is one-hot-or-zero per output, and the REQ-020 and REQ-022 rules hold.

Verification (N=4, M=2, DW=8, ARB=0, gnt_o=all-ones unless stated)
REQ-033 Inputs 0 and 2 send single flits to output 1 continuously -> grants alternate 0,2,0,2 and src_o alternates to match.
REQ-034 Input 1 sends a 3-flit packet (0xA1,0xA2,0xA3) to output 0 while input 3 requests output 0 from cycle 1 -> input 3 is granted only after 0xA3 transfers; no interleaving.
REQ-035 gnt_o[0] is held low for 5 cycles with traffic pending -> vld_o[0] stays high, dat_o[0] stays stable, and no flits are lost or duplicated.
REQ-036 Input 0 sends to output 0 and input 1 sends to output 1 at the same time -> both outputs transfer every cycle.
REQ-037 rst is asserted at flit 2 of a 4-flit packet -> next cycle vld_o=0 and the FSM is IDLE; after reset, the lowest-index requester wins first.
REQ-038 ARB=1 with inputs 0 and 3 requesting output 0 -> input 0 wins every cycle until vld_i[0] drops.

Source files
------------

// File: rtl/xsw_pkt_nm_pkg.sv
// Shared types and helpers for the packet crossbar.
package xsw_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } out_state_e;

    // clog2 that never returns 0, so single-entry indices stay 1 bit wide
    function automatic int clog2_safe(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/xsw_pkt_nm_if.sv
// Crossbar bus: N input ports (vld/dat/lst/dst -> gnt) and M output ports
// (vld/dat/lst/src -> gnt). slave is the switch view, master the environment.
interface xsw_pkt_nm_if
    import xsw_pkg::*;
#(
    parameter int N  = 2,
    parameter int M  = 2,
    parameter int DW = 8
);
    localparam int IW = clog2_safe(M);
    localparam int SW = clog2_safe(N);

    logic [N-1:0]          vld_i;
    logic [N-1:0][DW-1:0]  dat_i;
    logic [N-1:0]          lst_i;
    logic [N-1:0][IW-1:0]  dst_i;
    logic [N-1:0]          gnt_i;

    logic [M-1:0]          vld_o;
    logic [M-1:0][DW-1:0]  dat_o;
    logic [M-1:0]          lst_o;
    logic [M-1:0][SW-1:0]  src_o;
    logic [M-1:0]          gnt_o;

    modport master (
        output vld_i, dat_i, lst_i, dst_i, gnt_o,
        input  gnt_i, vld_o, dat_o, lst_o, src_o
    );

    modport slave (
        input  vld_i, dat_i, lst_i, dst_i, gnt_o,
        output gnt_i, vld_o, dat_o, lst_o, src_o
    );

endinterface

// File: rtl/xsw_pkt_nm_arb.sv
// Per-output arbiter: picks one requesting input in IDLE, then locks onto
// that owner until its last flit transfers so packets never interleave.
module xsw_pkt_arb
    import xsw_pkg::*;
#(
    parameter  int N   = 2,
    parameter  int ARB = 0,
    localparam int SW  = clog2_safe(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  lst,
    input  logic          acc,
    output logic [N-1:0]  gnt,
    output logic          win_vld,
    output logic [SW-1:0] win_idx
);

    out_state_e    state;
    logic [SW-1:0] owner;
    logic [SW-1:0] ptr;
    logic          xfer;

    // Winner select: owner when locked, else first requester from ptr upward
    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        if (state == ST_LOCK) begin
            win_vld = req[owner];
            win_idx = owner;
        end else begin
            // walk backwards so the closest requester to ptr is assigned last
            for (int k = N-1; k >= 0; k--) begin
                idx = (int'(ptr) + k) % N;
                if (req[idx]) begin
                    win_vld = 1'b1;
                    win_idx = SW'(idx);
                end
            end
        end
        if (rst) win_vld = 1'b0;
    end

    assign xfer = win_vld && acc;

    // Grant is the winner one-hot, only when the output path takes the flit
    always_comb begin
        gnt = '0;
        if (xfer) gnt[win_idx] = 1'b1;
    end

    // Output FSM: lock on a non-last flit, release on the last one
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            owner <= '0;
        end else if (xfer) begin
            if (lst[win_idx]) begin
                state <= ST_IDLE;
            end else begin
                state <= ST_LOCK;
                owner <= win_idx;
            end
        end
    end

    if (ARB == int'(ARB_RR)) begin : g_rr
        logic [SW-1:0] ptr_q;
        // Round-robin pointer advances past the owner only when a packet ends
        always_ff @(posedge clk) begin
            if (rst) begin
                ptr_q <= '0;
            end else if (xfer && lst[win_idx]) begin
                ptr_q <= (int'(win_idx) == N-1) ? '0 : win_idx + 1'b1;
            end
        end
        assign ptr = ptr_q;
    end else begin : g_fixed
        // fixed priority: search always starts at input 0
        assign ptr = '0;
    end

endmodule

// File: rtl/xsw_pkt_nm.sv
// N x M packet crossbar with per-output wormhole locking.
// Define XSW_PKT_NM_OUT_SLICE_EN to add a one-entry register slice on each
// output (1-cycle latency, full throughput); otherwise outputs are
// combinational with gnt_i derived directly from gnt_o.
module xsw_pkt_nm
    import xsw_pkg::*;
#(
    parameter int N   = 2,
    parameter int M   = 2,
    parameter int DW  = 8,
    parameter int ARB = 0
) (
    input  logic        clk,
    input  logic        rst,
    xsw_pkt_nm_if.slave bus
);

    localparam int IW = clog2_safe(M);
    localparam int SW = clog2_safe(N);

    logic [M-1:0][N-1:0]  req;
    logic [M-1:0][N-1:0]  agnt;
    logic [M-1:0]         win_vld;
    logic [M-1:0][SW-1:0] win_idx;
    logic [M-1:0]         acc;
    logic [N-1:0]         gnt_or;

    logic [M-1:0]         o_vld;
    logic [M-1:0][DW-1:0] o_dat;
    logic [M-1:0]         o_lst;
    logic [M-1:0][SW-1:0] o_src;

    // Requests per output; out-of-range destinations match no output
    always_comb begin
        req = '0;
        for (int j = 0; j < M; j++) begin
            for (int i = 0; i < N; i++) begin
                req[j][i] = bus.vld_i[i] && (int'(bus.dst_i[i]) == j);
            end
        end
    end

    // An input requests only one output, so OR-ing the per-output grants is safe
    always_comb begin
        gnt_or = '0;
        for (int j = 0; j < M; j++) gnt_or = gnt_or | agnt[j];
    end

    assign bus.gnt_i = gnt_or;
    assign bus.vld_o = o_vld;
    assign bus.dat_o = o_dat;
    assign bus.lst_o = o_lst;
    assign bus.src_o = o_src;

    for (genvar j = 0; j < M; j++) begin : g_out
        xsw_pkt_arb #(
            .N   (N),
            .ARB (ARB)
        ) u_arb (
            .clk     (clk),
            .rst     (rst),
            .req     (req[j]),
            .lst     (bus.lst_i),
            .acc     (acc[j]),
            .gnt     (agnt[j]),
            .win_vld (win_vld[j]),
            .win_idx (win_idx[j])
        );

`ifdef XSW_PKT_NM_OUT_SLICE_EN
        logic          vld_r;
        logic [DW-1:0] dat_r;
        logic          lst_r;
        logic [SW-1:0] src_r;

        // slice takes a new flit whenever it is empty or draining this cycle
        assign acc[j] = !vld_r || bus.gnt_o[j];

        // One-entry output slice
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_r <= 1'b0;
                dat_r <= '0;
                lst_r <= 1'b0;
                src_r <= '0;
            end else if (acc[j]) begin
                vld_r <= win_vld[j];
                if (win_vld[j]) begin
                    dat_r <= bus.dat_i[win_idx[j]];
                    lst_r <= bus.lst_i[win_idx[j]];
                    src_r <= win_idx[j];
                end
            end
        end

        assign o_vld[j] = vld_r;
        assign o_dat[j] = dat_r;
        assign o_lst[j] = lst_r;
        assign o_src[j] = src_r;
`else
        // pass-through: valid never looks at gnt_o, grant follows gnt_o
        assign acc[j]   = bus.gnt_o[j];
        assign o_vld[j] = win_vld[j];
        assign o_dat[j] = win_vld[j] ? bus.dat_i[win_idx[j]] : '0;
        assign o_lst[j] = win_vld[j] ? bus.lst_i[win_idx[j]] : 1'b0;
        assign o_src[j] = win_vld[j] ? win_idx[j] : '0;
`endif
    end

`ifndef SYNTHESIS
    logic [N-1:0]          hold_q;
    logic [N-1:0]          mid_q;
    logic [N-1:0][IW-1:0]  dst_q;
    logic [N-1:0][IW-1:0]  pdst_q;
    logic [N-1:0][DW-1:0]  dat_q;

    // Track stalled inputs and open packets for the protocol checks below
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            mid_q  <= '0;
            dst_q  <= '0;
            pdst_q <= '0;
            dat_q  <= '0;
        end else begin
            dst_q <= bus.dst_i;
            dat_q <= bus.dat_i;
            for (int i = 0; i < N; i++) begin
                hold_q[i] <= bus.vld_i[i] && !gnt_or[i];
                if (bus.vld_i[i] && gnt_or[i]) begin
                    mid_q[i]  <= !bus.lst_i[i];
                    pdst_q[i] <= bus.dst_i[i];
                end
            end
        end
    end

    // Grant sanity and input stability checks
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j < M; j++) begin
                assert ($onehot0(agnt[j]));
            end
            for (int i = 0; i < N; i++) begin
                assert (!(gnt_or[i] && int'(bus.dst_i[i]) >= M));
                assert (!(hold_q[i] && bus.vld_i[i]) ||
                        (bus.dst_i[i] == dst_q[i] && bus.dat_i[i] == dat_q[i]));
                assert (!(mid_q[i] && bus.vld_i[i]) || bus.dst_i[i] == pdst_q[i]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_xsw_pkt_nm.sv
// Directed bench for xsw_pkt_nm (N=4, M=2, DW=8): a round-robin instance
// driven from a vector table plus hand sequences, and a fixed-priority one.
module tb_xsw_pkt_nm;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    xsw_pkt_nm_if #(.N(4), .M(2), .DW(8)) bus ();
    xsw_pkt_nm_if #(.N(4), .M(2), .DW(8)) bf ();

    xsw_pkt_nm #(.N(4), .M(2), .DW(8), .ARB(0)) u_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    xsw_pkt_nm #(.N(4), .M(2), .DW(8), .ARB(1)) u_fx (
        .clk (clk),
        .rst (rst),
        .bus (bf)
    );

    typedef struct {
        string       name;
        logic [3:0]  vld;
        logic [3:0]  dst;   // one bit per input, input 3 leftmost
        logic [3:0]  lst;
        logic [31:0] dat;   // {in3,in2,in1,in0}
        logic [1:0]  go;
        logic [3:0]  e_gnt;
        logic [1:0]  e_vld;
        logic [1:0]  e_lst;
        logic [15:0] e_dat; // {out1,out0}
        logic [3:0]  e_src; // {src1,src0}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string nm, logic [3:0] vld, logic [3:0] dst,
                                logic [3:0] lst, logic [31:0] dat, logic [1:0] go,
                                logic [3:0] e_gnt, logic [1:0] e_vld,
                                logic [1:0] e_lst, logic [15:0] e_dat,
                                logic [3:0] e_src);
        vec_t v;
        v.name = nm;   v.vld = vld;     v.dst = dst;     v.lst = lst;
        v.dat = dat;   v.go = go;       v.e_gnt = e_gnt; v.e_vld = e_vld;
        v.e_lst = e_lst; v.e_dat = e_dat; v.e_src = e_src;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] vld, input logic [3:0] dst,
                         input logic [3:0] lst, input logic [31:0] dat,
                         input logic [1:0] go);
        bus.vld_i = vld;
        bus.dst_i = dst;
        bus.lst_i = lst;
        bus.dat_i = dat;
        bus.gnt_o = go;
    endtask

    task automatic chk_outs(input string nm, input logic [3:0] e_gnt,
                            input logic [1:0] e_vld, input logic [1:0] e_lst,
                            input logic [15:0] e_dat, input logic [3:0] e_src);
        chk({nm, " gnt_i"}, 32'(bus.gnt_i), 32'(e_gnt));
        chk({nm, " vld_o"}, 32'(bus.vld_o), 32'(e_vld));
        for (int j = 0; j < 2; j++) begin
            if (e_vld[j]) begin
                chk($sformatf("%s dat_o%0d", nm, j), 32'(bus.dat_o[j]), 32'(e_dat[8*j +: 8]));
                chk($sformatf("%s lst_o%0d", nm, j), 32'(bus.lst_o[j]), 32'(e_lst[j]));
                chk($sformatf("%s src_o%0d", nm, j), 32'(bus.src_o[j]), 32'(e_src[2*j +: 2]));
            end
        end
    endtask

    initial begin
        // alternating single flits from inputs 0 and 2 to output 1
        tbl.push_back(mk("A1", 4'b0101, 4'b0101, 4'b0101, 32'h0020_0010, 2'b11, 4'b0001, 2'b10, 2'b10, 16'h1000, 4'b0000));
        tbl.push_back(mk("A2", 4'b0101, 4'b0101, 4'b0101, 32'h0020_0011, 2'b11, 4'b0100, 2'b10, 2'b10, 16'h2000, 4'b1000));
        tbl.push_back(mk("A3", 4'b0101, 4'b0101, 4'b0101, 32'h0021_0011, 2'b11, 4'b0001, 2'b10, 2'b10, 16'h1100, 4'b0000));
        tbl.push_back(mk("A4", 4'b0101, 4'b0101, 4'b0101, 32'h0021_0012, 2'b11, 4'b0100, 2'b10, 2'b10, 16'h2100, 4'b1000));
        // 3-flit packet from input 1 holds output 0 against input 3
        tbl.push_back(mk("B0", 4'b0010, 4'b0000, 4'b0000, 32'h0000_A100, 2'b11, 4'b0010, 2'b01, 2'b00, 16'h00A1, 4'b0001));
        tbl.push_back(mk("B1", 4'b1010, 4'b0000, 4'b1000, 32'hB100_A200, 2'b11, 4'b0010, 2'b01, 2'b00, 16'h00A2, 4'b0001));
        tbl.push_back(mk("B2", 4'b1010, 4'b0000, 4'b1010, 32'hB100_A300, 2'b11, 4'b0010, 2'b01, 2'b01, 16'h00A3, 4'b0001));
        tbl.push_back(mk("B3", 4'b1010, 4'b0000, 4'b1010, 32'hB100_A400, 2'b11, 4'b1000, 2'b01, 2'b01, 16'h00B1, 4'b0011));
        tbl.push_back(mk("B4", 4'b0010, 4'b0000, 4'b0010, 32'h0000_A400, 2'b11, 4'b0010, 2'b01, 2'b01, 16'h00A4, 4'b0001));
        // output 0 back-pressured for 5 cycles
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk($sformatf("C%0d", k), 4'b0001, 4'b0000, 4'b0000, 32'h0000_00C1, 2'b10, 4'b0000, 2'b01, 2'b00, 16'h00C1, 4'b0000));
        tbl.push_back(mk("C5", 4'b0001, 4'b0000, 4'b0000, 32'h0000_00C1, 2'b11, 4'b0001, 2'b01, 2'b00, 16'h00C1, 4'b0000));
        tbl.push_back(mk("C6", 4'b0001, 4'b0000, 4'b0001, 32'h0000_00C2, 2'b11, 4'b0001, 2'b01, 2'b01, 16'h00C2, 4'b0000));
        // both outputs in parallel
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk($sformatf("D%0d", k), 4'b0011, 4'b0010, 4'b0011, 32'h0000_E0D0 + 32'h0000_0101 * k,
                             2'b11, 4'b0011, 2'b11, 2'b11, 16'hE0D0 + 16'h0101 * k, 4'b0100));
        tbl.push_back(mk("IDLE", 4'b0000, 4'b0000, 4'b0000, 32'h0, 2'b11, 4'b0000, 2'b00, 2'b00, 16'h0, 4'b0000));

        // reset state with every input requesting
        rst = 1'b1;
        drive(4'b1111, 4'b0110, 4'b1111, 32'h4433_2211, 2'b11);
        bf.vld_i = 4'b1111; bf.dst_i = '0; bf.lst_i = 4'b1111;
        bf.dat_i = 32'h4433_2211; bf.gnt_o = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("RST gnt_i", 32'(bus.gnt_i), 32'h0);
        chk("RST vld_o", 32'(bus.vld_o), 32'h0);
        chk("RST dat_o", 32'(bus.dat_o), 32'h0);
        chk("RST lst_o", 32'(bus.lst_o), 32'h0);
        chk("RST src_o", 32'(bus.src_o), 32'h0);
        chk("RST fx gnt_i", 32'(bf.gnt_i), 32'h0);
        chk("RST fx vld_o", 32'(bf.vld_o), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        bf.vld_i = '0;

        foreach (tbl[r]) begin
            drive(tbl[r].vld, tbl[r].dst, tbl[r].lst, tbl[r].dat, tbl[r].go);
            @(negedge clk);
            chk_outs(tbl[r].name, tbl[r].e_gnt, tbl[r].e_vld, tbl[r].e_lst, tbl[r].e_dat, tbl[r].e_src);
            @(posedge clk); #1;
        end

        // reset at flit 2 of a 4-flit packet from input 2 to output 0
        drive(4'b0100, 4'b0000, 4'b0000, 32'h00F1_0000, 2'b11);
        @(negedge clk);
        chk_outs("R1", 4'b0100, 2'b01, 2'b00, 16'h00F1, 4'b0010);
        @(posedge clk); #1;
        drive(4'b0100, 4'b0000, 4'b0000, 32'h00F2_0000, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        chk("R2 gnt_i", 32'(bus.gnt_i), 32'h0);
        chk("R2 vld_o", 32'(bus.vld_o), 32'h0);
        chk("R2 dat_o", 32'(bus.dat_o), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        // packet dropped; lowest requester of each output must win
        drive(4'b1111, 4'b0110, 4'b1111, 32'h4433_2211, 2'b11);
        @(negedge clk);
        chk_outs("R3", 4'b0011, 2'b11, 2'b11, 16'h2211, 4'b0100);
        @(posedge clk); #1;
        drive(4'b0000, 4'b0000, 4'b0000, 32'h0, 2'b11);

        // fixed priority: input 0 beats input 3 until it drops
        for (int k = 0; k < 3; k++) begin
            bf.vld_i = 4'b1001; bf.dst_i = '0; bf.lst_i = 4'b1001;
            bf.dat_i = {8'h30, 16'h0, 8'(k + 1)};
            @(negedge clk);
            chk($sformatf("FX%0d gnt_i", k), 32'(bf.gnt_i), 32'h1);
            chk($sformatf("FX%0d src_o0", k), 32'(bf.src_o[0]), 32'h0);
            chk($sformatf("FX%0d dat_o0", k), 32'(bf.dat_o[0]), 32'(k + 1));
            @(posedge clk); #1;
        end
        bf.vld_i = 4'b1000;
        @(negedge clk);
        chk("FX3 gnt_i", 32'(bf.gnt_i), 32'h8);
        chk("FX3 src_o0", 32'(bf.src_o[0]), 32'h3);
        chk("FX3 dat_o0", 32'(bf.dat_o[0]), 32'h30);
        @(posedge clk); #1;
        bf.vld_i = '0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
